// File: rtl/wb_io_intc_if.sv
// Wishbone I/O slave bus bundle for wb_io_intc.
//
// Handshake: the master raises wb_cyc_i & wb_stb_i (with address, tags, selects
// and write data stable) to request a transfer. The slave answers with exactly
// one cycle of wb_ack_o, one clock after it samples the request. wb_dat_o is
// valid only while wb_ack_o is high. A request that is still present after the
// ack cycle is taken as a new transfer. inta_i marks an interrupt-vector fetch.
interface wb_io_intc_if;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic [19:1] wb_adr_i;
  logic        wb_we_i;
  logic [1:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_tga_i;
  logic        inta_i;
  logic        wb_ack_o;

  modport master (
    output wb_dat_i, wb_adr_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_tga_i, inta_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_dat_i, wb_adr_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_tga_i, inta_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_io_intc.sv
// Wishbone I/O-space block: NREGS byte data registers plus a small
// edge-triggered interrupt controller (mask register, pending register,
// vector fetch on inta cycles). Single-cycle registered acknowledge.
module wb_io_intc #(
  parameter logic [15:0] BASE     = 16'h00B7,
  parameter int          NREGS    = 2,
  parameter int          NIRQ     = 4,
  parameter logic [7:0]  VEC_BASE = 8'h03
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  wb_io_intc_if.slave     bus,
  input  logic [NIRQ-1:0] irq_i,
  output logic            intr_o,
  output logic            dbg_state_o
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  // Byte offsets of the controller registers inside the window.
  localparam logic [15:0] IMR_OFF = 16'(NREGS);
  localparam logic [15:0] IPR_OFF = 16'(NREGS + 1);

  state_t          state_q, state_d;
  logic [7:0]      dr_q [NREGS];
  logic [7:0]      dr_d [NREGS];
  logic [NIRQ-1:0] imr_q, imr_d;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic [NIRQ-1:0] irq_q;
  logic [15:0]     dat_q, dat_d;
  logic            intr_q;

  logic [15:0]     lane_off [2];
  logic [1:0]      lane_dec;
  logic            io_hit;
  logic            vec_cyc;
  logic            start;
  logic [NIRQ-1:0] unmasked;
  logic [NIRQ-1:0] vec_clr;
  logic [NIRQ-1:0] pend_clr;
  logic [NIRQ-1:0] irq_edge;
  logic            unused_adr;

  // Only the low 16 bits of the byte address select I/O registers.
  assign unused_adr = ^bus.wb_adr_i[19:16];

  // Per-lane byte offset from BASE and whether that byte lies in the window.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      lane_off[n] = {bus.wb_adr_i[15:1], n[0]} - BASE;
      lane_dec[n] = (lane_off[n] <= IPR_OFF);
    end
  end

  assign io_hit   = bus.wb_cyc_i & bus.wb_stb_i & bus.wb_tga_i & ~bus.inta_i
                  & |(bus.wb_sel_i & lane_dec);
  assign vec_cyc  = bus.wb_cyc_i & bus.wb_stb_i & bus.inta_i;
  assign start    = (state_q == IDLE) & (io_hit | vec_cyc);
  assign unmasked = pend_q & ~imr_q;
  // Isolates the lowest set bit: that is the interrupt served by a vector fetch.
  assign vec_clr  = unmasked & (~unmasked + NIRQ'(1));
  assign irq_edge = irq_i & ~irq_q;

  // Next-state logic: every accepted request gets exactly one ACK cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io_hit || vec_cyc) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register writes, read-data mux and vector selection, all applied on the IDLE->ACK edge.
  always_comb begin
    dr_d     = dr_q;
    imr_d    = imr_q;
    pend_clr = '0;
    dat_d    = '0;
    if (start) begin
      if (vec_cyc) begin
        // Spurious fetch returns one past the last vector and changes nothing.
        dat_d = {8'h00, VEC_BASE + 8'(NIRQ)};
        for (int i = NIRQ - 1; i >= 0; i--) begin
          if (unmasked[i]) dat_d = {8'h00, VEC_BASE + 8'(i)};
        end
        pend_clr = vec_clr;
      end else begin
        for (int n = 0; n < 2; n++) begin
          if (bus.wb_sel_i[n] && lane_dec[n]) begin
            if (bus.wb_we_i) begin
              for (int k = 0; k < NREGS; k++) begin
                if (lane_off[n] == 16'(k)) dr_d[k] = bus.wb_dat_i[8*n +: 8];
              end
              if (lane_off[n] == IMR_OFF) imr_d = bus.wb_dat_i[8*n +: NIRQ];
              if (lane_off[n] == IPR_OFF) pend_clr = pend_clr | bus.wb_dat_i[8*n +: NIRQ];
            end else begin
              for (int k = 0; k < NREGS; k++) begin
                if (lane_off[n] == 16'(k)) dat_d[8*n +: 8] = dr_q[k];
              end
              if (lane_off[n] == IMR_OFF) dat_d[8*n +: 8] = 8'(imr_q);
              if (lane_off[n] == IPR_OFF) dat_d[8*n +: 8] = 8'(pend_q);
            end
          end
        end
      end
    end
  end

  // Pending bits: clear first, then a new edge sets, so a same-edge set wins.
  always_comb begin
    pend_d = (pend_q & ~pend_clr) | irq_edge;
  end

  // All state; reset is asynchronous and aborts any transfer in flight.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      dat_q   <= '0;
      imr_q   <= '0;
      pend_q  <= '0;
      irq_q   <= '0;
      intr_q  <= 1'b0;
      for (int k = 0; k < NREGS; k++) dr_q[k] <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      imr_q   <= imr_d;
      pend_q  <= pend_d;
      irq_q   <= irq_i;
      intr_q  <= |unmasked;
      for (int k = 0; k < NREGS; k++) dr_q[k] <= dr_d[k];
    end
  end

  assign bus.wb_ack_o = (state_q == ACK);
  assign bus.wb_dat_o = dat_q;
  assign intr_o       = intr_q;
  assign dbg_state_o  = (state_q == ACK);

endmodule

// File: tb/tb_wb_io_intc.sv
// Directed bench for wb_io_intc with a byte-map level reference model and a
// per-cycle compare process; directed steps also pin hand-computed values.
module tb_wb_io_intc;
  localparam logic [15:0] BASE  = 16'h00B7;
  localparam int          NREGS = 2;
  localparam int          NIRQ  = 4;
  localparam logic [7:0]  VEC   = 8'h03;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] irq   = 4'h0;
  logic       intr;
  logic       dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  wb_io_intc_if bus ();

  wb_io_intc #(
    .BASE    (BASE),
    .NREGS   (NREGS),
    .NIRQ    (NIRQ),
    .VEC_BASE(VEC)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .bus        (bus.slave),
    .irq_i      (irq),
    .intr_o     (intr),
    .dbg_state_o(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  m_dr [NREGS];
  logic [3:0]  m_imr  = '0;
  logic [3:0]  m_pend = '0;
  logic [3:0]  m_prev = '0;
  logic        m_ack  = 1'b0;
  logic        m_intr = 1'b0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [3:0]  unm;
    logic [3:0]  clr;
    logic [15:0] off;
    logic [15:0] nd;
    logic        n_ack;
    logic        hit;
    logic        n_intr;
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) m_dr[k] = 8'h00;
      m_imr = '0; m_pend = '0; m_prev = '0; m_ack = 1'b0; m_intr = 1'b0;
      exp_q.delete();
    end else begin
      unm    = m_pend & ~m_imr;
      n_intr = (unm != 4'h0);
      clr    = '0;
      n_ack  = 1'b0;
      nd     = '0;
      if (!m_ack && bus.wb_cyc_i && bus.wb_stb_i) begin
        if (bus.inta_i) begin
          n_ack = 1'b1;
          nd    = {8'h00, VEC + 8'(NIRQ)};
          for (int i = 0; i < NIRQ; i++) begin
            if (unm[i]) begin
              nd  = {8'h00, VEC + 8'(i)};
              clr = 4'(1 << i);
              break;
            end
          end
        end else if (bus.wb_tga_i) begin
          hit = 1'b0;
          for (int n = 0; n < 2; n++) begin
            off = {bus.wb_adr_i[15:1], 1'(n)} - BASE;
            if (bus.wb_sel_i[n] && int'(off) < NREGS + 2) hit = 1'b1;
          end
          if (hit) begin
            n_ack = 1'b1;
            for (int n = 0; n < 2; n++) begin
              off = {bus.wb_adr_i[15:1], 1'(n)} - BASE;
              if (bus.wb_sel_i[n] && int'(off) < NREGS + 2) begin
                if (bus.wb_we_i) begin
                  if (int'(off) < NREGS) m_dr[int'(off)] = bus.wb_dat_i[8*n +: 8];
                  else if (int'(off) == NREGS) m_imr = bus.wb_dat_i[8*n +: 4];
                  else clr = clr | bus.wb_dat_i[8*n +: 4];
                end else begin
                  if (int'(off) < NREGS) nd[8*n +: 8] = m_dr[int'(off)];
                  else if (int'(off) == NREGS) nd[8*n +: 8] = {4'h0, m_imr};
                  else nd[8*n +: 8] = {4'h0, m_pend};
                end
              end
            end
          end
        end
      end
      if (n_ack) exp_q.push_back(nd);
      m_pend = (m_pend & ~clr) | (irq & ~m_prev);
      m_prev = irq;
      m_ack  = n_ack;
      m_intr = n_intr;
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    check("ack", bus.wb_ack_o, m_ack);
    check("state", dbg_state, m_ack);
    check("intr", intr, m_intr);
    if (bus.wb_ack_o) begin
      check("exp_q_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dat_o", bus.wb_dat_o, e);
      end
    end else begin
      check("dat_idle", bus.wb_dat_o, 16'h0000);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_bus();
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_sel_i = 2'b00; bus.wb_tga_i = 1'b0; bus.inta_i = 1'b0;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0;
  endtask

  // One Wishbone request; lat = cycles to ack, -1 if no ack within 5 cycles.
  task automatic wb_xfer(input logic we, input logic [18:0] adr, input logic [1:0] sel,
                         input logic [15:0] wdat, input logic tga, input logic inta,
                         output logic [15:0] rd, output int lat);
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = adr; bus.wb_sel_i = sel; bus.wb_dat_i = wdat;
    bus.wb_tga_i = tga; bus.inta_i = inta;
    lat = -1;
    rd  = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (bus.wb_ack_o) begin
        lat = c;
        rd  = bus.wb_dat_o;
        break;
      end
    end
    idle_bus();
  endtask

  task automatic io_wr(input string name, input logic [18:0] adr, input logic [1:0] sel,
                       input logic [15:0] wdat);
    logic [15:0] rd;
    int lat;
    wb_xfer(1'b1, adr, sel, wdat, 1'b1, 1'b0, rd, lat);
    check({name, "_lat"}, lat, 1);
  endtask

  task automatic io_rd(input string name, input logic [18:0] adr, input logic [1:0] sel,
                       input logic [15:0] exp);
    logic [15:0] rd;
    int lat;
    wb_xfer(1'b0, adr, sel, 16'h0000, 1'b1, 1'b0, rd, lat);
    check({name, "_lat"}, lat, 1);
    check(name, rd, exp);
  endtask

  task automatic vec_rd(input string name, input logic [15:0] exp);
    logic [15:0] rd;
    int lat;
    wb_xfer(1'b0, 19'h0, 2'b00, 16'h0000, 1'b0, 1'b1, rd, lat);
    check({name, "_lat"}, lat, 1);
    check(name, rd, exp);
  endtask

  task automatic pulse_irq(input logic [3:0] bits);
    @(negedge clk); irq = bits;
    @(negedge clk); irq = 4'h0;
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] rd;
    logic [3:0]  pat;
    int lat;
    idle_bus();
    repeat (3) @(negedge clk);
    check("reset_ack", bus.wb_ack_o, 1'b0);
    check("reset_dat", bus.wb_dat_o, 16'h0000);
    check("reset_intr", intr, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // data registers across both byte lanes
    io_wr("wr_dr0", 19'h5B, 2'b10, 16'hA500);
    io_wr("wr_dr1", 19'h5C, 2'b01, 16'h005A);
    io_rd("rd_dr0", 19'h5B, 2'b10, 16'hA500);
    io_rd("rd_dr1", 19'h5C, 2'b01, 16'h005A);
    io_rd("rd_dr0_undec_lane", 19'h5B, 2'b11, 16'hA500);
    io_rd("rd_dr1_imr", 19'h5C, 2'b11, 16'h005A);

    // misses: memory cycle, and a word entirely below the window
    wb_xfer(1'b1, 19'h5B, 2'b10, 16'h1100, 1'b0, 1'b0, rd, lat);
    check("miss_tga0_lat", lat, -1);
    wb_xfer(1'b1, 19'h5A, 2'b11, 16'h2233, 1'b1, 1'b0, rd, lat);
    check("miss_5a_lat", lat, -1);
    wb_xfer(1'b1, 19'h5B, 2'b00, 16'h4400, 1'b1, 1'b0, rd, lat);
    check("miss_nosel_lat", lat, -1);
    io_rd("rd_dr0_after_miss", 19'h5B, 2'b10, 16'hA500);

    // held strobe acks every other cycle
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_tga_i = 1'b1;
    bus.wb_adr_i = 19'h5C; bus.wb_sel_i = 2'b01;
    pat = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      pat = {pat[2:0], bus.wb_ack_o};
    end
    idle_bus();
    check("held_stb_pattern", pat, 4'b1010);

    // two edges, served lowest first
    @(negedge clk); irq = 4'b0100;
    @(negedge clk); check("intr_after_1", intr, 1'b0); irq = 4'b0010;
    @(negedge clk); check("intr_after_2", intr, 1'b1); irq = 4'b0000;
    vec_rd("vec_irq1", 16'h0004);
    vec_rd("vec_irq2", 16'h0005);
    repeat (2) @(negedge clk);
    check("intr_cleared", intr, 1'b0);

    // masking and write-1-to-clear
    io_wr("wr_imr", 19'h5C, 2'b10, 16'h0100);
    pulse_irq(4'b0001);
    repeat (3) @(negedge clk);
    check("intr_masked", intr, 1'b0);
    io_rd("rd_ipr_masked", 19'h5D, 2'b01, 16'h0001);
    io_wr("w1c_ipr", 19'h5D, 2'b01, 16'h0001);
    io_rd("rd_ipr_cleared", 19'h5D, 2'b01, 16'h0000);
    io_rd("rd_imr", 19'h5C, 2'b10, 16'h0100);
    io_wr("wr_imr_ff", 19'h5C, 2'b10, 16'hFF00);
    io_rd("rd_imr_nirq_bits", 19'h5C, 2'b10, 16'h0F00);
    io_wr("wr_imr_0", 19'h5C, 2'b10, 16'h0000);

    // spurious vector, then set and serve on the same edge
    vec_rd("vec_spurious", 16'h0007);
    io_rd("rd_ipr_spurious", 19'h5D, 2'b01, 16'h0000);
    pulse_irq(4'b1000);
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.inta_i = 1'b1; irq = 4'b1000;
    @(negedge clk);
    check("vec_same_edge_ack", bus.wb_ack_o, 1'b1);
    check("vec_same_edge_dat", bus.wb_dat_o, 16'h0006);
    idle_bus(); irq = 4'b0000;
    io_rd("rd_ipr_set_wins", 19'h5D, 2'b01, 16'h0008);
    io_wr("w1c_ipr3", 19'h5D, 2'b01, 16'h0008);
    io_rd("rd_ipr3_cleared", 19'h5D, 2'b01, 16'h0000);

    // reset in the middle of an ack
    io_wr("wr_dr0_a5", 19'h5B, 2'b10, 16'hA500);
    pulse_irq(4'b0100);
    repeat (2) @(negedge clk);
    check("intr_before_rst", intr, 1'b1);
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_tga_i = 1'b1;
    bus.wb_adr_i = 19'h5B; bus.wb_sel_i = 2'b10;
    @(negedge clk);
    check("pre_rst_ack", bus.wb_ack_o, 1'b1);
    check("pre_rst_dat", bus.wb_dat_o, 16'hA500);
    #1 rst_n = 1'b0; irq = 4'b0001;
    #1;
    check("rst_ack_drop", bus.wb_ack_o, 1'b0);
    check("rst_intr_drop", intr, 1'b0);
    check("rst_dat_drop", bus.wb_dat_o, 16'h0000);
    @(negedge clk);
    check("rst_held_no_ack", bus.wb_ack_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_new_ack", bus.wb_ack_o, 1'b1);
    check("post_rst_dr0", bus.wb_dat_o, 16'h0000);
    idle_bus();
    @(negedge clk);
    check("post_rst_edge_intr", intr, 1'b1);
    irq = 4'b0000;
    io_rd("rd_ipr_post_rst", 19'h5D, 2'b01, 16'h0001);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_io_intc.md
WB_IO_INTC -- requirements
Module: wb_io_intc

Interface
REQ-001 Parameter BASE, default 16'h00B7: byte I/O address of data register 0.
REQ-002 Parameter NREGS, default 2, range 1..8: number of 8-bit data registers.
REQ-003 Parameter NIRQ, default 4, range 1..8: number of interrupt inputs.
REQ-004 Parameter VEC_BASE, default 8'h03: vector returned for irq_i[0].
REQ-005 wb_clk_i  in  1  sole clock; all state on rising edge.
REQ-006 wb_rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 wb_dat_i  in  16  write data; byte lane 0 = [7:0], lane 1 = [15:8].
REQ-008 wb_dat_o  out  16  read/vector data, valid while wb_ack_o=1, else 0.
REQ-009 wb_adr_i  in  19  word address [19:1]; lane n byte address = {wb_adr_i[15:1], n}.
REQ-010 wb_we_i  in  1  write enable.
REQ-011 wb_sel_i  in  2  byte-lane selects.
REQ-012 wb_stb_i, wb_cyc_i  in  1 each  Wishbone strobe, cycle.
REQ-013 wb_tga_i  in  1  1 = I/O space; block ignores memory cycles.
REQ-014 wb_ack_o  out  1  registered acknowledge.
REQ-015 irq_i  in  NIRQ  synchronous interrupt requests, rising-edge sensitive.
REQ-016 intr_o  out  1  interrupt request to CPU.
REQ-017 inta_i  in  1  interrupt-acknowledge tag from CPU, qualifies a vector-fetch cycle.

Function
REQ-018 Byte map from BASE: offsets 0..NREGS-1 = data regs DR[k] (R/W); NREGS = IMR (R/W, bit i masks irq i); NREGS+1 = IPR (read pending; write 1 clears); other offsets not decoded.
REQ-019 I/O hit: wb_cyc_i & wb_stb_i & wb_tga_i & ~inta_i & some selected lane maps into window; vector cycle: wb_cyc_i & wb_stb_i & inta_i.
REQ-020 FSM states IDLE, ACK; IDLE->ACK on hit or vector cycle; ACK->IDLE unconditionally; wb_ack_o=1 exactly in ACK.
REQ-021 Latency one cycle: ack on the edge after strobe sampled; held strobe yields ack pattern 1,0,1,0.
REQ-022 Writes commit on the IDLE->ACK edge, per selected lane only; unselected/undecoded lanes unchanged.
REQ-023 Read data registered on IDLE->ACK edge; each selected decoded lane returns its byte, other lanes 0.
REQ-024 Misses (outside window, tga=0, no sel) are never acked; FSM stays IDLE.
REQ-025 Edge detect: pending[i] sets when irq_i[i]=1 and previous-cycle sample was 0; level held high sets once.
REQ-026 intr_o registered = |(pending & ~IMR[NIRQ-1:0]); updates one cycle after pending/IMR change.
REQ-027 Vector cycle: idx = lowest set bit of pending & ~IMR sampled on IDLE->ACK edge; wb_dat_o = {8'h00, VEC_BASE+idx}; pending[idx] cleared same edge.
REQ-028 Spurious vector cycle (nothing unmasked pending): return VEC_BASE+NIRQ, no state change.
REQ-029 Same-edge set and clear (ack or W1C) of one pending bit: set wins.
REQ-030 Vector arithmetic 8-bit, wraps modulo 256.
REQ-031 IMR/IPR bits at index >= NIRQ read 0, writes ignored.

Reset
REQ-032 wb_rst_ni=0 asynchronously forces: FSM IDLE, wb_ack_o=0, wb_dat_o=0, DR[*]=0, IMR=0, pending=0, irq sample=0, intr_o=0.
REQ-033 Reset mid-transfer aborts it without ack; strobe still high after release is a new transfer.
REQ-034 Input already high at reset release is recorded as an edge on the first clock.

Verification (defaults)
REQ-035 Write word 0x5B sel=2'b10 dat=16'hA500, then word 0x5C sel=2'b01 dat=16'h005A -> reads return 16'hA500 and 16'h005A, each ack one cycle after stb.
REQ-036 tga=0 or word address 0x5A with stb held 5 cycles -> wb_ack_o stays 0, registers unchanged.
REQ-037 Pulse irq_i[2], then irq_i[1] -> intr_o=1 two cycles after first edge; vector cycles return 16'h0004 then 16'h0005; intr_o=0 afterwards.
REQ-038 IMR=8'h01, pulse irq_i[0] -> intr_o stays 0, IPR reads 8'h01; write IPR 8'h01 -> IPR reads 0.
REQ-039 Vector cycle with nothing pending -> wb_dat_o=16'h0007, pending unchanged; irq edge on same edge as ack of that bit -> bit remains set.
REQ-040 Assert wb_rst_ni=0 mid-ack with DR[0]=8'hA5 -> wb_ack_o and intr_o drop immediately, DR[0] reads 0 after release.
